// File: rtl/toast_dmem_pkg.sv
// Shared definitions for the ToastCore data-memory responder.
// Holds the responder FSM state encoding, the read-select encoding and
// the default addresses of the test-harness registers.
package toast_dmem_pkg;

   // Responder run state: counting, or finished with a pass/fail verdict.
   typedef enum logic [1:0] {
      DM_RUN       = 2'b00,
      DM_DONE_PASS = 2'b01,
      DM_DONE_FAIL = 2'b10
   } dmem_state_t;

   // Source selected for the read-data output in the cycle after an access.
   typedef enum logic [1:0] {
      RS_ZERO = 2'b00,
      RS_RAM  = 2'b01,
      RS_SIDE = 2'b10
   } rd_sel_t;

   localparam logic [31:0] DMEM_TOHOST_ADDR = 32'h8000_1000;
   localparam logic [31:0] DMEM_CYCLE_ADDR  = 32'h8000_1004;

endpackage

// File: rtl/toast_sp_ram.sv
// Single-port word RAM, read-first, with a registered output that has a
// synchronous clear. Kept free of asynchronous reset so FPGA tools can map
// it onto block RAM.
// Ports:
//   Clk      in   1       clock
//   Addr     in   ADDR_W  word index
//   Wr_en    in   1       full-word write strobe
//   Wr_data  in   32      write data
//   Rd_clr   in   1       synchronous clear of the output register
//   Rd_data  out  32      registered read data (old word on same-word write)
module toast_sp_ram #(
   parameter int DEPTH  = 2048,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              Clk,
   input  logic [ADDR_W-1:0] Addr,
   input  logic              Wr_en,
   input  logic [31:0]       Wr_data,
   input  logic              Rd_clr,
   output logic [31:0]       Rd_data
);

   logic [31:0] mem_r [DEPTH];
   logic [31:0] rd_data_r;

   // Write port: full-word store on strobe.
   always_ff @(posedge Clk) begin
      if (Wr_en) begin
         mem_r[Addr] <= Wr_data;
      end
   end

   // Read port: samples the array before this edge's write lands (read-first).
   always_ff @(posedge Clk) begin
      if (Rd_clr) begin
         rd_data_r <= 32'h0000_0000;
      end else begin
         rd_data_r <= mem_r[Addr];
      end
   end

   assign Rd_data = rd_data_r;

endmodule

// File: rtl/toast_dmem_responder.sv
// Data-memory responder for the ToastCore DMEM port: word RAM with a
// one-cycle registered read, a tohost status register that ends the test,
// a free-running cycle counter that freezes once the test is done, and a
// sticky flag for writes to misaligned or unmapped addresses.
// Ports:
//   Clk           in   1   clock, all state on rising edge
//   Reset         in   1   asynchronous active-high reset
//   DMEM_addr     in   32  byte address from core
//   DMEM_wr_data  in   32  write data
//   DMEM_wr_en    in   1   full-word write strobe
//   DMEM_rst      in   1   synchronous clear of read data, blocks writes
//   DMEM_rd_data  out  32  registered read data
//   Test_done     out  1   tohost written with an odd value (sticky)
//   Test_pass     out  1   tohost value was 1
//   Test_num      out  31  failing test number, 0 on pass
//   Addr_err      out  1   sticky: misaligned/unmapped write seen
module toast_dmem_responder
   import toast_dmem_pkg::*;
#(
   parameter int          DEPTH_WORDS = 2048,
   parameter logic [31:0] TOHOST_ADDR = DMEM_TOHOST_ADDR,
   parameter logic [31:0] CYCLE_ADDR  = DMEM_CYCLE_ADDR
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [31:0] DMEM_addr,
   input  logic [31:0] DMEM_wr_data,
   input  logic        DMEM_wr_en,
   input  logic        DMEM_rst,
   output logic [31:0] DMEM_rd_data,
   output logic        Test_done,
   output logic        Test_pass,
   output logic [30:0] Test_num,
   output logic        Addr_err
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);

   logic        ram_hit_s;
   logic        tohost_hit_s;
   logic        cycle_hit_s;
   logic        wr_ok_s;
   logic        ram_we_s;
   logic        tohost_we_s;
   logic        bad_wr_s;
   logic [31:0] ram_rd_s;
   logic [31:0] rd_mux_s;

   dmem_state_t state_r;
   dmem_state_t next_state_s;
   rd_sel_t     sel_r;
   logic [31:0] side_r;
   logic [31:0] tohost_r;
   logic [31:0] cycle_r;
   logic        done_r;
   logic        pass_r;
   logic [30:0] num_r;
   logic        err_r;

   // Address decode; a write in the cycle Reset rises is dropped.
   assign ram_hit_s    = (DMEM_addr[1:0] == 2'b00) &&
                         ({2'b00, DMEM_addr[31:2]} < 32'(DEPTH_WORDS));
   assign tohost_hit_s = (DMEM_addr == TOHOST_ADDR);
   assign cycle_hit_s  = (DMEM_addr == CYCLE_ADDR);
   assign wr_ok_s      = DMEM_wr_en && !DMEM_rst && !Reset;
   assign ram_we_s     = wr_ok_s && ram_hit_s;
   assign tohost_we_s  = wr_ok_s && tohost_hit_s;
   assign bad_wr_s     = wr_ok_s && !ram_hit_s && !tohost_hit_s && !cycle_hit_s;

   toast_sp_ram #(
      .DEPTH  (DEPTH_WORDS),
      .ADDR_W (IDX_W)
   ) u_ram (
      .Clk     (Clk),
      .Addr    (DMEM_addr[IDX_W+1:2]),
      .Wr_en   (ram_we_s),
      .Wr_data (DMEM_wr_data),
      .Rd_clr  (DMEM_rst),
      .Rd_data (ram_rd_s)
   );

   // Next state: only an odd tohost value written while running ends the test.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         DM_RUN: begin
            if (tohost_we_s && DMEM_wr_data[0]) begin
               next_state_s = (DMEM_wr_data == 32'd1) ? DM_DONE_PASS : DM_DONE_FAIL;
            end else begin
               next_state_s = DM_RUN;
            end
         end
         DM_DONE_PASS: next_state_s = DM_DONE_PASS;
         DM_DONE_FAIL: next_state_s = DM_DONE_FAIL;
         default:      next_state_s = DM_RUN;
      endcase
   end

   // State, harness registers, verdict outputs and read-select capture.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_r  <= DM_RUN;
         cycle_r  <= 32'd0;
         tohost_r <= 32'd0;
         done_r   <= 1'b0;
         pass_r   <= 1'b0;
         num_r    <= 31'd0;
         err_r    <= 1'b0;
         sel_r    <= RS_ZERO;
         side_r   <= 32'd0;
      end else begin
         state_r <= next_state_s;
         if (state_r == DM_RUN) begin
            cycle_r <= cycle_r + 32'd1;
            if (tohost_we_s) begin
               tohost_r <= DMEM_wr_data;
            end
         end
         if ((state_r == DM_RUN) && (next_state_s != DM_RUN)) begin
            done_r <= 1'b1;
            pass_r <= (next_state_s == DM_DONE_PASS);
            num_r  <= (next_state_s == DM_DONE_PASS) ? 31'd0 : DMEM_wr_data[31:1];
         end
         if (bad_wr_s) begin
            err_r <= 1'b1;
         end
         // Side registers are snapshotted so the output is a pure register mux.
         if (DMEM_rst) begin
            sel_r <= RS_ZERO;
         end else if (ram_hit_s) begin
            sel_r <= RS_RAM;
         end else if (tohost_hit_s) begin
            sel_r  <= RS_SIDE;
            side_r <= tohost_r;
         end else if (cycle_hit_s) begin
            sel_r  <= RS_SIDE;
            side_r <= cycle_r;
         end else begin
            sel_r <= RS_ZERO;
         end
      end
   end

   // Read-data mux driven only by registered sources.
   always_comb begin
      rd_mux_s = 32'd0;
      case (sel_r)
         RS_RAM:  rd_mux_s = ram_rd_s;
         RS_SIDE: rd_mux_s = side_r;
         RS_ZERO: rd_mux_s = 32'd0;
         default: rd_mux_s = 32'd0;
      endcase
   end

   assign DMEM_rd_data = rd_mux_s;
   assign Test_done    = done_r;
   assign Test_pass    = pass_r;
   assign Test_num     = num_r;
   assign Addr_err     = err_r;

endmodule

// File: tb/tb_toast_dmem_responder.sv
// Directed self-checking bench for toast_dmem_responder.
module tb_toast_dmem_responder;

   logic        Clk;
   logic        Reset;
   logic [31:0] DMEM_addr;
   logic [31:0] DMEM_wr_data;
   logic        DMEM_wr_en;
   logic        DMEM_rst;
   logic [31:0] DMEM_rd_data;
   logic        Test_done;
   logic        Test_pass;
   logic [30:0] Test_num;
   logic        Addr_err;

   int compared   = 0;
   int mismatched = 0;
   int run_edges  = 0;
   int exp_cyc    = 0;
   bit model_run  = 1'b1;

   localparam logic [31:0] TOHOST = 32'h8000_1000;
   localparam logic [31:0] CYCLE  = 32'h8000_1004;

   toast_dmem_responder dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .DMEM_addr    (DMEM_addr),
      .DMEM_wr_data (DMEM_wr_data),
      .DMEM_wr_en   (DMEM_wr_en),
      .DMEM_rst     (DMEM_rst),
      .DMEM_rd_data (DMEM_rd_data),
      .Test_done    (Test_done),
      .Test_pass    (Test_pass),
      .Test_num     (Test_num),
      .Addr_err     (Addr_err)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // One clock edge; exp_cyc holds the counter value a CYCLE read returns.
   task automatic tick();
      exp_cyc = run_edges;
      @(posedge Clk);
      if (model_run) run_edges = run_edges + 1;
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared = compared + 1;
      assert (obs === exp) else begin
         mismatched = mismatched + 1;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [31:0] a, input logic we, input logic [31:0] d);
      DMEM_addr    = a;
      DMEM_wr_en   = we;
      DMEM_wr_data = d;
   endtask

   task automatic chk_flags(input string tag, input logic d, input logic p,
                            input logic [30:0] n, input logic e);
      chk({tag, "_done"}, {31'd0, Test_done}, {31'd0, d});
      chk({tag, "_pass"}, {31'd0, Test_pass}, {31'd0, p});
      chk({tag, "_num"},  {1'b0, Test_num},   {1'b0, n});
      chk({tag, "_err"},  {31'd0, Addr_err},  {31'd0, e});
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      drive(32'h0, 1'b0, 32'h0);
      DMEM_rst = 1'b0;
      tick();
      tick();
      Reset     = 1'b0;
      run_edges = 0;
      model_run = 1'b1;
   endtask

   initial begin
      Reset = 1'b1;
      DMEM_rst = 1'b0;
      drive(32'h0, 1'b0, 32'h0);
      do_reset();

      // Reset state
      chk("rst_rd", DMEM_rd_data, 32'h0);
      chk_flags("rst", 1'b0, 1'b0, 31'd0, 1'b0);

      // Cycle counter starts at zero and counts
      drive(CYCLE, 1'b0, 32'h0); tick();
      chk("cyc0", DMEM_rd_data, 32'd0);
      tick();
      chk("cyc1", DMEM_rd_data, 32'd1);

      // 1: write then read with one-cycle latency
      drive(32'h10, 1'b1, 32'hDEAD_BEEF); tick();
      drive(32'h10, 1'b0, 32'h0);         tick();
      chk("t1_rd", DMEM_rd_data, 32'hDEAD_BEEF);
      drive(32'h0, 1'b0, 32'h0);          tick();

      // 2: read-first on same-word write
      drive(32'h20, 1'b1, 32'h5); tick();
      drive(32'h20, 1'b1, 32'h1); tick();
      chk("t2_old", DMEM_rd_data, 32'h5);
      drive(32'h20, 1'b0, 32'h0); tick();
      chk("t2_new", DMEM_rd_data, 32'h1);

      // 3: DMEM_rst clears read data and blocks writes
      drive(32'h10, 1'b1, 32'h1234_5678); DMEM_rst = 1'b1; tick();
      chk("t3_clr", DMEM_rd_data, 32'h0);
      DMEM_rst = 1'b0; drive(32'h10, 1'b0, 32'h0); tick();
      chk("t3_keep", DMEM_rd_data, 32'hDEAD_BEEF);

      // 6: unmapped write above the RAM, writes to CYCLE are harmless
      drive(CYCLE, 1'b1, 32'hFFFF_FFFF); tick();
      chk("t6_cycwr_err", {31'd0, Addr_err}, 32'd0);
      drive(32'h0, 1'b1, 32'h11); tick();
      drive(32'h2000, 1'b1, 32'hBBBB_BBBB); tick();
      chk("t6_oob_err", {31'd0, Addr_err}, 32'd1);
      drive(32'h0, 1'b0, 32'h0); tick();
      chk("t6_oob_ram", DMEM_rd_data, 32'h11);
      drive(32'h2000, 1'b0, 32'h0); tick();
      chk("t6_oob_rd", DMEM_rd_data, 32'h0);

      // Reset mid-access: outputs clear, the in-flight write is lost
      drive(32'h10, 1'b1, 32'hBAD0_BAD0); Reset = 1'b1; tick();
      chk("rst2_rd", DMEM_rd_data, 32'h0);
      chk_flags("rst2", 1'b0, 1'b0, 31'd0, 1'b0);
      Reset = 1'b0; run_edges = 0; model_run = 1'b1;
      drive(32'h10, 1'b0, 32'h0); tick();
      chk("rst2_ram", DMEM_rd_data, 32'hDEAD_BEEF);

      // 6: misaligned write
      drive(32'h12, 1'b1, 32'hAAAA_AAAA); tick();
      chk("t6_mis_err", {31'd0, Addr_err}, 32'd1);
      drive(32'h10, 1'b0, 32'h0); tick();
      chk("t6_mis_ram", DMEM_rd_data, 32'hDEAD_BEEF);
      drive(32'h12, 1'b0, 32'h0); tick();
      chk("t6_mis_rd", DMEM_rd_data, 32'h0);

      // 5: even tohost ignored, odd != 1 fails with number val>>1
      drive(TOHOST, 1'b1, 32'h2); tick();
      chk_flags("t5_even", 1'b0, 1'b0, 31'd0, 1'b1);
      drive(TOHOST, 1'b1, 32'h7); tick();
      model_run = 1'b0;
      chk_flags("t5_fail", 1'b1, 1'b0, 31'd3, 1'b1);

      // 4: pass, counter freezes, later tohost writes ignored
      do_reset();
      drive(32'h0, 1'b0, 32'h0); tick(); tick(); tick();
      drive(TOHOST, 1'b1, 32'h1); tick();
      model_run = 1'b0;
      chk_flags("t4_pass", 1'b1, 1'b1, 31'd0, 1'b0);
      drive(CYCLE, 1'b0, 32'h0); tick();
      chk("t4_cyc_a", DMEM_rd_data, 32'd4);
      chk("t4_cyc_m", DMEM_rd_data, exp_cyc[31:0]);
      tick(); tick();
      chk("t4_cyc_b", DMEM_rd_data, 32'd4);
      drive(TOHOST, 1'b1, 32'h7); tick();
      chk_flags("t4_after", 1'b1, 1'b1, 31'd0, 1'b0);
      drive(TOHOST, 1'b0, 32'h0); tick();
      chk("t4_tohost_rd", DMEM_rd_data, 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
